// File: rtl/leaf_out_arbiter_pkg.sv
// Shared definitions for the leaf output arbiter: default field widths,
// packet-field offset helpers and the output-stage state enumeration.
package leaf_out_arbiter_pkg;

  // Default BFT field widths
  localparam int unsigned LeafPayloadBits = 32;
  localparam int unsigned LeafNumLeafBits = 5;
  localparam int unsigned LeafNumPortBits = 4;
  localparam int unsigned LeafNumAddrBits = 7;
  localparam int unsigned LeafPacketBits  = 49;

  // Packet layout, MSB first: valid | dst_leaf | dst_port | seq | payload
  function automatic int unsigned leaf_packet_bits(input int unsigned leaf_bits,
                                                   input int unsigned port_bits,
                                                   input int unsigned addr_bits,
                                                   input int unsigned payload_bits);
    return 1 + leaf_bits + port_bits + addr_bits + payload_bits;
  endfunction

  function automatic int unsigned leaf_seq_lsb(input int unsigned payload_bits);
    return payload_bits;
  endfunction

  function automatic int unsigned leaf_port_lsb(input int unsigned payload_bits,
                                                input int unsigned addr_bits);
    return payload_bits + addr_bits;
  endfunction

  function automatic int unsigned leaf_leaf_lsb(input int unsigned payload_bits,
                                                input int unsigned addr_bits,
                                                input int unsigned port_bits);
    return payload_bits + addr_bits + port_bits;
  endfunction

  // Output stage: Idle = register empty, Send = fresh packet, Hold = packet carried over,
  // Replay = upstream resend in progress
  typedef enum logic [1:0] {
    StIdle,
    StSend,
    StHold,
    StReplay
  } leaf_state_e;

endpackage

// File: rtl/leaf_skid_fifo.sv
// Per-channel skid FIFO. Full/empty come only from the registered count so the
// upstream ready never combinationally depends on a same-cycle pop.
module leaf_skid_fifo #(
  parameter int unsigned PAYLOAD_BITS = 32,
  parameter int unsigned FIFO_DEPTH   = 4
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    i_push,
  input  logic [PAYLOAD_BITS-1:0] i_data,
  input  logic                    i_pop,
  output logic [PAYLOAD_BITS-1:0] o_data,
  output logic                    o_full,
  output logic                    o_empty
);

  localparam int unsigned PtrBits = $clog2(FIFO_DEPTH);
  localparam int unsigned CntBits = PtrBits + 1;

  logic [PAYLOAD_BITS-1:0] r_mem [FIFO_DEPTH];
  logic [PtrBits-1:0]      r_wr_ptr;
  logic [PtrBits-1:0]      r_rd_ptr;
  logic [CntBits-1:0]      r_count;
  logic                    w_push;
  logic                    w_pop;

  assign o_full  = (r_count == CntBits'(FIFO_DEPTH));
  assign o_empty = (r_count == '0);
  assign w_push  = i_push && !o_full;
  assign w_pop   = i_pop && !o_empty;
  assign o_data  = r_mem[r_rd_ptr];

  // Storage array, no reset needed since occupancy is tracked by the count
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= i_data;
    end
  end

  // Pointers and occupancy count
  always_ff @(posedge clk) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PtrBits'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PtrBits'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CntBits'(1);
        2'b01:   r_count <= r_count - CntBits'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/leaf_out_arbiter.sv
// Leaf output arbiter: per-channel skid FIFOs, credit-gated round-robin
// arbitration, per-channel sequence numbers and a single output packet register
// that honours BFT backpressure and upstream replay requests.
module leaf_out_arbiter
  import leaf_out_arbiter_pkg::*;
#(
  parameter int unsigned PACKET_BITS   = LeafPacketBits,
  parameter int unsigned PAYLOAD_BITS  = LeafPayloadBits,
  parameter int unsigned NUM_LEAF_BITS = LeafNumLeafBits,
  parameter int unsigned NUM_PORT_BITS = LeafNumPortBits,
  parameter int unsigned NUM_ADDR_BITS = LeafNumAddrBits,
  parameter int unsigned NUM_OUT_PORTS = 2,
  parameter int unsigned FIFO_DEPTH    = 4,
  parameter int unsigned CREDIT_BITS   = 8,
  parameter int unsigned INIT_CREDIT   = 128
) (
  input  logic                                  clk,
  input  logic                                  reset,
  input  logic [NUM_OUT_PORTS*PAYLOAD_BITS-1:0] din_leaf_user2interface,
  input  logic [NUM_OUT_PORTS-1:0]              vld_user2interface,
  output logic [NUM_OUT_PORTS-1:0]              ack_interface2user,
  input  logic                                  cfg_wr_en,
  input  logic [3:0]                            cfg_chan,
  input  logic [NUM_LEAF_BITS-1:0]              cfg_leaf,
  input  logic [NUM_PORT_BITS-1:0]              cfg_port,
  input  logic                                  credit_upd_vld,
  input  logic [3:0]                            credit_upd_chan,
  input  logic [CREDIT_BITS-1:0]                credit_upd_amt,
  input  logic                                  resend,
  input  logic                                  bft_ready,
  output logic [PACKET_BITS-1:0]                dout_leaf_interface2bft,
  output logic [NUM_OUT_PORTS-1:0]              chan_stalled
);

  localparam int unsigned ChanBits = (NUM_OUT_PORTS > 1) ? $clog2(NUM_OUT_PORTS) : 1;
  localparam int unsigned SeqLsb   = leaf_seq_lsb(PAYLOAD_BITS);
  localparam int unsigned PortLsb  = leaf_port_lsb(PAYLOAD_BITS, NUM_ADDR_BITS);
  localparam int unsigned LeafLsb  = leaf_leaf_lsb(PAYLOAD_BITS, NUM_ADDR_BITS, NUM_PORT_BITS);
  localparam int unsigned ValidBit = PACKET_BITS - 1;

  if (PACKET_BITS != leaf_packet_bits(NUM_LEAF_BITS, NUM_PORT_BITS, NUM_ADDR_BITS,
                                      PAYLOAD_BITS)) begin : g_bad_packet_bits
    $error("PACKET_BITS must equal 1 + leaf + port + addr + payload widths");
  end
  if (NUM_OUT_PORTS < 1 || NUM_OUT_PORTS > 15) begin : g_bad_num_ports
    $error("NUM_OUT_PORTS must be in 1..15");
  end
  if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_fifo_depth
    $error("FIFO_DEPTH must be a power of two and at least 2");
  end

  logic [NUM_OUT_PORTS-1:0] w_full;
  logic [NUM_OUT_PORTS-1:0] w_empty;
  logic [NUM_OUT_PORTS-1:0] w_pop;
  logic [NUM_OUT_PORTS-1:0] w_elig;
  logic [PAYLOAD_BITS-1:0]  w_head     [NUM_OUT_PORTS];
  logic [CREDIT_BITS-1:0]   r_credit   [NUM_OUT_PORTS];
  logic [CREDIT_BITS-1:0]   w_credit_d [NUM_OUT_PORTS];
  logic [NUM_ADDR_BITS-1:0] r_seq      [NUM_OUT_PORTS];
  logic [NUM_LEAF_BITS-1:0] r_leaf     [NUM_OUT_PORTS];
  logic [NUM_PORT_BITS-1:0] r_port     [NUM_OUT_PORTS];
  logic [NUM_OUT_PORTS-1:0] r_stalled;
  logic [ChanBits-1:0]      r_last;
  logic [ChanBits-1:0]      w_grant_idx;
  logic                     w_grant_vld;
  logic [PACKET_BITS-1:0]   r_out;
  logic [PACKET_BITS-1:0]   w_pkt;
  logic                     w_out_vld;
  logic                     w_can_load;
  leaf_state_e              r_state;
  leaf_state_e              w_state_d;

  for (genvar g = 0; g < NUM_OUT_PORTS; g++) begin : g_chan
    leaf_skid_fifo #(
      .PAYLOAD_BITS(PAYLOAD_BITS),
      .FIFO_DEPTH  (FIFO_DEPTH)
    ) u_fifo (
      .clk    (clk),
      .reset  (reset),
      .i_push (vld_user2interface[g]),
      .i_data (din_leaf_user2interface[g*PAYLOAD_BITS +: PAYLOAD_BITS]),
      .i_pop  (w_pop[g]),
      .o_data (w_head[g]),
      .o_full (w_full[g]),
      .o_empty(w_empty[g])
    );
  end

  assign ack_interface2user = ~w_full;
  assign chan_stalled       = r_stalled;
  assign w_out_vld          = r_out[ValidBit];

  // Eligibility: data waiting and at least one credit (resend gates via w_can_load)
  always_comb begin
    w_elig = '0;
    for (int i = 0; i < NUM_OUT_PORTS; i++) begin
      w_elig[i] = !w_empty[i] && (r_credit[i] != '0);
    end
  end

  // Round-robin search starting one past the last granted channel
  always_comb begin
    logic [ChanBits-1:0] idx;
    w_grant_vld = 1'b0;
    w_grant_idx = '0;
    idx         = '0;
    for (int unsigned k = 1; k <= NUM_OUT_PORTS; k++) begin
      idx = ChanBits'((32'(r_last) + k) % NUM_OUT_PORTS);
      if (w_can_load && !w_grant_vld && w_elig[idx]) begin
        w_grant_vld = 1'b1;
        w_grant_idx = idx;
      end
    end
  end

  // Pop strobes and assembly of the granted packet
  always_comb begin
    w_pop = '0;
    for (int i = 0; i < NUM_OUT_PORTS; i++) begin
      w_pop[i] = w_grant_vld && (w_grant_idx == ChanBits'(i));
    end
    w_pkt                           = '0;
    w_pkt[ValidBit]                 = 1'b1;
    w_pkt[LeafLsb +: NUM_LEAF_BITS] = r_leaf[w_grant_idx];
    w_pkt[PortLsb +: NUM_PORT_BITS] = r_port[w_grant_idx];
    w_pkt[SeqLsb +: NUM_ADDR_BITS]  = r_seq[w_grant_idx];
    w_pkt[0 +: PAYLOAD_BITS]        = w_head[w_grant_idx];
  end

  // Credit next-state: return and consume net out, result saturates at all-ones
  always_comb begin
    logic [CREDIT_BITS:0] sum;
    sum = '0;
    for (int i = 0; i < NUM_OUT_PORTS; i++) begin
      sum = {1'b0, r_credit[i]};
      if (credit_upd_vld && (credit_upd_chan == 4'(i))) begin
        sum = sum + {1'b0, credit_upd_amt};
      end
      // A grant implies credit > 0, so this never underflows
      if (w_pop[i]) begin
        sum = sum - (CREDIT_BITS + 1)'(1);
      end
      w_credit_d[i] = sum[CREDIT_BITS] ? '1 : sum[CREDIT_BITS-1:0];
    end
  end

  // Per-channel credit, sequence, destination table, stall flag and RR pointer
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NUM_OUT_PORTS; i++) begin
        r_credit[i]  <= CREDIT_BITS'(INIT_CREDIT);
        r_seq[i]     <= '0;
        r_leaf[i]    <= '0;
        r_port[i]    <= NUM_PORT_BITS'(i + 1);
        r_stalled[i] <= 1'b0;
      end
      r_last <= ChanBits'(NUM_OUT_PORTS - 1);
    end else begin
      for (int i = 0; i < NUM_OUT_PORTS; i++) begin
        r_credit[i] <= w_credit_d[i];
        if (w_pop[i]) begin
          r_seq[i] <= r_seq[i] + NUM_ADDR_BITS'(1);
        end
        if (cfg_wr_en && (cfg_chan == 4'(i))) begin
          r_leaf[i] <= cfg_leaf;
          r_port[i] <= cfg_port;
        end
        r_stalled[i] <= !w_empty[i] && (r_credit[i] == '0);
      end
      if (w_grant_vld) begin
        r_last <= w_grant_idx;
      end
    end
  end

  // Output packet register: reload (with a grant or empty) whenever allowed
  always_ff @(posedge clk) begin
    if (reset) begin
      r_out <= '0;
    end else if (w_can_load) begin
      r_out <= w_grant_vld ? w_pkt : '0;
    end
  end

  // FSM state register
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_state_d;
    end
  end

  // FSM next state: replay wins, otherwise track what the output register will hold
  always_comb begin
    w_state_d = r_state;
    if (resend) begin
      w_state_d = StReplay;
    end else if (w_can_load) begin
      w_state_d = w_grant_vld ? StSend : StIdle;
    end else begin
      w_state_d = w_out_vld ? StHold : StIdle;
    end
  end

  // FSM outputs: when the output register may reload, and the masked packet bus
  always_comb begin
    w_can_load = 1'b0;
    unique case (r_state)
      StIdle:         w_can_load = !resend;
      StSend, StHold: w_can_load = !resend && bft_ready;
      StReplay:       w_can_load = !resend && (!w_out_vld || bft_ready);
      default:        w_can_load = 1'b0;
    endcase
    dout_leaf_interface2bft = resend ? '0 : r_out;
  end

endmodule

// File: tb/tb_leaf_out_arbiter.sv
// Directed self-checking bench for leaf_out_arbiter with default parameters.
module tb_leaf_out_arbiter;

  logic        clk;
  logic        reset;
  logic [63:0] din;
  logic [1:0]  vld;
  logic [1:0]  ack;
  logic        cfg_wr_en;
  logic [3:0]  cfg_chan;
  logic [4:0]  cfg_leaf;
  logic [3:0]  cfg_port;
  logic        credit_upd_vld;
  logic [3:0]  credit_upd_chan;
  logic [7:0]  credit_upd_amt;
  logic        resend;
  logic        bft_ready;
  logic [48:0] dout;
  logic [1:0]  stalled;

  int n_checks = 0;
  int n_err    = 0;

  leaf_out_arbiter dut (
    .clk                    (clk),
    .reset                  (reset),
    .din_leaf_user2interface(din),
    .vld_user2interface     (vld),
    .ack_interface2user     (ack),
    .cfg_wr_en              (cfg_wr_en),
    .cfg_chan               (cfg_chan),
    .cfg_leaf               (cfg_leaf),
    .cfg_port               (cfg_port),
    .credit_upd_vld         (credit_upd_vld),
    .credit_upd_chan        (credit_upd_chan),
    .credit_upd_amt         (credit_upd_amt),
    .resend                 (resend),
    .bft_ready              (bft_ready),
    .dout_leaf_interface2bft(dout),
    .chan_stalled           (stalled)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [48:0] pkt(input logic [4:0] lf, input logic [3:0] pt,
                                      input logic [6:0] sq, input logic [31:0] pl);
    return {1'b1, lf, pt, sq, pl};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic idle_inputs();
    din             = '0;
    vld             = '0;
    cfg_wr_en       = 1'b0;
    cfg_chan        = '0;
    cfg_leaf        = '0;
    cfg_port        = '0;
    credit_upd_vld  = 1'b0;
    credit_upd_chan = '0;
    credit_upd_amt  = '0;
    resend          = 1'b0;
    bft_ready       = 1'b0;
  endtask

  task automatic do_reset();
    idle_inputs();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    #1;
  endtask

  initial begin
    reset = 1'b1;
    idle_inputs();

    // Reset state
    do_reset();
    chk("rst_dout", 64'(dout), 64'd0);
    chk("rst_ack", 64'(ack), 64'd3);
    chk("rst_stalled", 64'(stalled), 64'd0);

    // Single word on channel 0: visible two edges after the push
    din[31:0] = 32'hA5A5_0001;
    vld       = 2'b01;
    bft_ready = 1'b1;
    tick();
    vld = 2'b00;
    chk("single_lat1", 64'(dout), 64'd0);
    tick();
    chk("single_pkt", 64'(dout), 64'(pkt(5'd0, 4'd1, 7'd0, 32'hA5A5_0001)));
    tick();
    chk("single_drain", 64'(dout), 64'd0);

    // Fairness: both channels always valid, grants alternate 0,1,0,1...
    do_reset();
    din       = {32'hC1C1_0000, 32'hC0C0_0000};
    vld       = 2'b11;
    bft_ready = 1'b1;
    tick();
    chk("rr_first", 64'(dout), 64'd0);
    for (int k = 0; k < 6; k++) begin
      tick();
      chk($sformatf("rr_%0d", k), 64'(dout),
          64'(pkt(5'd0, 4'((k % 2) + 1), 7'(k / 2), (k % 2 == 1) ? 32'hC1C1_0000 : 32'hC0C0_0000)));
    end

    // Reset mid-transfer discards the held packet and the FIFO contents
    vld   = 2'b00;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    #1;
    chk("midrst_dout", 64'(dout), 64'd0);
    chk("midrst_ack", 64'(ack), 64'd3);
    tick();
    tick();
    chk("midrst_flushed", 64'(dout), 64'd0);

    // Backpressure: output held stable, FIFO fills, ack drops
    do_reset();
    bft_ready = 1'b0;
    vld       = 2'b01;
    din[31:0] = 32'hB000_0000;
    tick();
    for (int j = 1; j <= 5; j++) begin
      din[31:0] = 32'hB000_0000 + 32'(j);
      tick();
      chk($sformatf("bp_hold_%0d", j), 64'(dout), 64'(pkt(5'd0, 4'd1, 7'd0, 32'hB000_0000)));
      chk($sformatf("bp_ack_%0d", j), 64'(ack[0]), (j <= 3) ? 64'd1 : 64'd0);
    end
    vld       = 2'b00;
    bft_ready = 1'b1;
    tick();
    chk("bp_rel_pkt1", 64'(dout), 64'(pkt(5'd0, 4'd1, 7'd1, 32'hB000_0001)));
    chk("bp_rel_ack", 64'(ack[0]), 64'd1);
    tick();
    chk("bp_rel_pkt2", 64'(dout), 64'(pkt(5'd0, 4'd1, 7'd2, 32'hB000_0002)));
    tick();
    chk("bp_rel_pkt3", 64'(dout), 64'(pkt(5'd0, 4'd1, 7'd3, 32'hB000_0003)));
    tick();
    chk("bp_rel_pkt4", 64'(dout), 64'(pkt(5'd0, 4'd1, 7'd4, 32'hB000_0004)));
    tick();
    chk("bp_rel_empty", 64'(dout), 64'd0);

    // Resend for three cycles while a packet is held
    do_reset();
    vld       = 2'b01;
    din[31:0] = 32'hD000_0000;
    tick();
    din[31:0] = 32'hD000_0001;
    tick();
    vld = 2'b00;
    chk("rs_held", 64'(dout), 64'(pkt(5'd0, 4'd1, 7'd0, 32'hD000_0000)));
    resend = 1'b1;
    #1;
    chk("rs_zero0", 64'(dout), 64'd0);
    tick();
    chk("rs_zero1", 64'(dout), 64'd0);
    tick();
    chk("rs_zero2", 64'(dout), 64'd0);
    tick();
    chk("rs_zero3", 64'(dout), 64'd0);
    resend = 1'b0;
    #1;
    chk("rs_again", 64'(dout), 64'(pkt(5'd0, 4'd1, 7'd0, 32'hD000_0000)));
    bft_ready = 1'b1;
    tick();
    chk("rs_next_seq", 64'(dout), 64'(pkt(5'd0, 4'd1, 7'd1, 32'hD000_0001)));
    tick();
    chk("rs_empty", 64'(dout), 64'd0);

    // Destination table: valid write to channel 1, out-of-range write ignored
    do_reset();
    cfg_wr_en = 1'b1;
    cfg_chan  = 4'd1;
    cfg_leaf  = 5'h1F;
    cfg_port  = 4'd9;
    tick();
    cfg_chan = 4'd3;
    cfg_leaf = 5'd7;
    cfg_port = 4'd7;
    tick();
    cfg_wr_en = 1'b0;
    din       = {32'hE1E1_0000, 32'hE0E0_0000};
    vld       = 2'b11;
    bft_ready = 1'b1;
    tick();
    vld = 2'b00;
    tick();
    chk("cfg_ch0_default", 64'(dout), 64'(pkt(5'd0, 4'd1, 7'd0, 32'hE0E0_0000)));
    tick();
    chk("cfg_ch1_written", 64'(dout), 64'(pkt(5'h1F, 4'd9, 7'd0, 32'hE1E1_0000)));

    // Sequence wrap and credit exhaustion on channel 0
    do_reset();
    bft_ready = 1'b1;
    vld       = 2'b01;
    for (int j = 0; j < 132; j++) begin
      din[31:0] = 32'(j);
      tick();
      if (j >= 1 && j <= 128) begin
        chk($sformatf("wrap_pkt_%0d", j - 1), 64'(dout),
            64'(pkt(5'd0, 4'd1, 7'(j - 1), 32'(j - 1))));
      end else begin
        chk($sformatf("wrap_idle_%0d", j), 64'(dout), 64'd0);
      end
    end
    vld = 2'b00;
    chk("cr_stalled", 64'(stalled), 64'd1);
    chk("cr_ack_full", 64'(ack), 64'd2);

    // Credit to an out-of-range channel has no effect
    credit_upd_vld  = 1'b1;
    credit_upd_chan = 4'd2;
    credit_upd_amt  = 8'd5;
    tick();
    credit_upd_vld = 1'b0;
    tick();
    chk("cr_oor_dout", 64'(dout), 64'd0);
    chk("cr_oor_stalled", 64'(stalled), 64'd1);

    // Returning credit releases the queued words; the first carries the wrapped seq 0
    credit_upd_vld  = 1'b1;
    credit_upd_chan = 4'd0;
    credit_upd_amt  = 8'd4;
    tick();
    credit_upd_vld = 1'b0;
    tick();
    chk("cr_wrap_seq0", 64'(dout), 64'(pkt(5'd0, 4'd1, 7'd0, 32'd128)));
    chk("cr_stall_clr", 64'(stalled), 64'd0);
    tick();
    chk("cr_seq1", 64'(dout), 64'(pkt(5'd0, 4'd1, 7'd1, 32'd129)));
    tick();
    chk("cr_seq2", 64'(dout), 64'(pkt(5'd0, 4'd1, 7'd2, 32'd130)));
    tick();
    chk("cr_seq3", 64'(dout), 64'(pkt(5'd0, 4'd1, 7'd3, 32'd131)));
    tick();
    chk("cr_done_dout", 64'(dout), 64'd0);
    chk("cr_done_ack", 64'(ack), 64'd3);
    chk("cr_done_stalled", 64'(stalled), 64'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

// File: doc/leaf_out_arbiter.md
LEAF_OUT_ARBITER -- requirements
Module: leaf_out_arbiter

Interface
REQ-001 Parameters (name, default, meaning):
- PACKET_BITS, 49, BFT packet width.
- PAYLOAD_BITS, 32, user word width.
- NUM_LEAF_BITS, 5, destination leaf field width.
- NUM_PORT_BITS, 4, destination port field width.
- NUM_ADDR_BITS, 7, sequence/address field width.
- NUM_OUT_PORTS, 2, user output channels (1..15).
- FIFO_DEPTH, 4, per-channel skid FIFO entries (power of 2, ≥2).
- CREDIT_BITS, 8, credit counter width.
- INIT_CREDIT, 128, credits per channel after reset.

REQ-002 Ports (name, direction, width, meaning):
- clk, in, 1, sole clock.
- reset, in, 1, synchronous active-high reset.
- din_leaf_user2interface, in, NUM_OUT_PORTS*PAYLOAD_BITS, user words; channel i is at slice i.
- vld_user2interface, in, NUM_OUT_PORTS, per-channel valid.
- ack_interface2user, out, NUM_OUT_PORTS, per-channel ready.
- cfg_wr_en, in, 1, destination-table write strobe.
- cfg_chan, in, 4, channel index to write.
- cfg_leaf, in, NUM_LEAF_BITS, destination leaf.
- cfg_port, in, NUM_PORT_BITS, destination port.
- credit_upd_vld, in, 1, credit return strobe.
- credit_upd_chan, in, 4, channel receiving credit.
- credit_upd_amt, in, CREDIT_BITS, credits returned.
- resend, in, 1, upstream replay request.
- bft_ready, in, 1, BFT accepts a packet this cycle.
- dout_leaf_interface2bft, out, PACKET_BITS, outgoing packet.
- chan_stalled, out, NUM_OUT_PORTS, channel i has data but zero credit.

REQ-003 Clock and reset are decided: one clock, clk; reset is synchronous and active-high, named reset.

Function
REQ-004 Packet layout, MSB first: valid(1) | dst_leaf | dst_port | seq(NUM_ADDR_BITS) | payload; PACKET_BITS SHALL equal the sum of these fields, checked at elaboration.
REQ-005 Each channel SHALL own a FIFO_DEPTH skid FIFO; ack_interface2user[i] = FIFO not full; a word is accepted when vld & ack are both high.
REQ-006 Simultaneous push and pop on a full FIFO SHALL still deassert ack for that cycle (ack depends only on the registered count).
REQ-007 A channel is eligible when its FIFO is non-empty, its credit > 0, and resend = 0.
REQ-008 The arbiter is round-robin: the search starts at last-granted+1 and wraps from NUM_OUT_PORTS-1 to 0; at most one grant per cycle.
REQ-009 The output register SHALL load the granted packet when it is empty or when bft_ready = 1 (one-cycle latency from FIFO head to dout).
REQ-010 The output SHALL hold a packet stable while valid = 1 and bft_ready = 0.
REQ-011 Each grant SHALL pop one FIFO entry, decrement that channel's credit, and increment that channel's seq (wrapping at 2^NUM_ADDR_BITS).
REQ-012 A credit update and a decrement on the same channel in the same cycle SHALL net out (credit + amt - 1); the credit counter saturates at 2^CREDIT_BITS-1.
REQ-013 When resend = 1:
- dout_leaf_interface2bft SHALL be driven all-zero;
- no grants are issued;
- the held packet is retained and presented again after resend falls.
REQ-014 A cfg write SHALL take effect for packets granted from the next cycle; writes to cfg_chan ≥ NUM_OUT_PORTS and credit updates to out-of-range channels SHALL be ignored.
REQ-015 chan_stalled[i] = FIFO non-empty & credit == 0 (registered).
REQ-016 States: IDLE (output empty), SEND (output valid), HOLD (valid & !bft_ready), REPLAY (resend = 1). Transitions:
- REPLAY has priority from any state;
- REPLAY returns to HOLD if a packet is held, otherwise to IDLE.

Reset
REQ-017 Reset SHALL set:
- FIFOs empty;
- ack_interface2user all 1 on the first post-reset cycle;
- credits = INIT_CREDIT;
- seq = 0;
- round-robin pointer = NUM_OUT_PORTS-1 (so channel 0 wins first);
- destination table: leaf 0, port i+1 for channel i;
- dout = 0; chan_stalled = 0; state IDLE.
REQ-018 Reset asserted mid-transfer SHALL discard the held packet and all FIFO contents with no partial output.

Structure
REQ-019 The field widths, the packet-field offset constants and the state enumeration belong in the shared leaf package.
REQ-020 The per-channel FIFO is a sub-module, leaf_skid_fifo (parameters PAYLOAD_BITS, FIFO_DEPTH), instantiated NUM_OUT_PORTS times.

Verification
REQ-021 Single channel: push 0xA5A5_0001 on channel 0 after reset, bft_ready = 1 -> packet {1, leaf 0, port 1, seq 0, 0xA5A50001} appears exactly 2 cycles later.
REQ-022 Fairness: both channels always valid, bft_ready = 1 -> grants alternate 0, 1, 0, 1; seq per channel increments 0, 1, 2, ...
REQ-023 Credit: INIT_CREDIT = 2 with 3 words on channel 1 -> 2 packets sent, then chan_stalled[1] = 1; credit_upd_amt = 1 -> third packet sent and stall clears.
REQ-024 Backpressure: bft_ready = 0 for 5 cycles -> dout stable; the FIFO fills and ack drops after FIFO_DEPTH accepts.
REQ-025 Resend: assert for 3 cycles while a packet is held -> dout = 0 during resend, then the same packet reappears; no seq skipped.
REQ-026 Seq wrap: send 128 packets on channel 0 -> the 129th carries seq 0.
